pwm_spi_cmd_ctrl: RTL

- SPI slave command controller that configures the 7-channel PWM datapath.
- Deserialises 2-byte SPI frames from the host: a command byte followed by a data byte.
- Write frames issue one-cycle `pset` strobes carrying a channel address and an 8-bit level to the PWM level registers.
- Read frames shift the addressed channel's current level back out on `miso`.
- Sits between the chip pins (`sclk`/`cs`/`mosi`/`miso`) and the PWM level register bank, in the same `clk` domain.

---
 rtl/pwm_spi_cmd_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pwm_spi_cmd_ctrl.sv
// SPI mode-0 slave that turns 2-byte command/data frames into PWM level writes
// and reads back channel levels; every SPI pin is resynchronised into clk.
module pwm_spi_cmd_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVICE_ID   = 8'hA7,
    parameter int         NUM_CH      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       pset,
    output logic [2:0] addr,
    output logic [7:0] level,
    output logic [2:0] rd_addr,
    input  logic [7:0] rd_level,
    output logic       busy,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_s, cs_s, mosi_s, sclk_d;
    logic       rise, fall, byte_done, cmd_ok;
    logic [7:0] rx_byte;
    logic [6:0] in_sr;
    logic [7:0] out_sr;
    logic [2:0] bit_cnt;
    logic       cmd_wr;
    logic [2:0] cmd_addr;
    logic       ld_pend, ld_rd;
    logic       wr_pend;
    logic [7:0] wr_level;

    // cs synchroniser presets to "deselected" so a reset never fakes a frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_d;
    assign fall      = ~sclk_s & sclk_d;
    assign rx_byte   = {in_sr, mosi_s};
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign cmd_ok    = (rx_byte[6:3] == 4'd0) && ({1'b0, rx_byte[2:0]} < NUM_CH_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cs_s) state_nxt = CMD;
            CMD:     if (byte_done) state_nxt = cmd_ok ? DATA : IGNORE;
            DATA:    if (byte_done) state_nxt = IGNORE;
            default: state_nxt = state;
        endcase
        // Deselect wins, but only after the same-cycle edge has been consumed above
        if (state != IDLE && cs_s) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            in_sr     <= '0;
            out_sr    <= DEVICE_ID;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            ld_pend   <= 1'b0;
            ld_rd     <= 1'b0;
            wr_pend   <= 1'b0;
            wr_level  <= '0;
            pset      <= 1'b0;
            addr      <= '0;
            level     <= '0;
            rd_addr   <= '0;
            err_count <= '0;
        end else begin
            wr_pend <= 1'b0;
            pset    <= wr_pend;
            if (wr_pend) begin
                addr  <= cmd_addr;
                level <= wr_level;
            end
            if (state == IDLE) begin
                bit_cnt <= '0;
                ld_pend <= 1'b0;
                if (!cs_s) out_sr <= DEVICE_ID;
            end else begin
                if (rise) begin
                    in_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done && state == CMD) begin
                        cmd_wr   <= rx_byte[7];
                        cmd_addr <= rx_byte[2:0];
                        if (cmd_ok) begin
                            // reply byte is loaded on the next fall, not shifted
                            ld_pend <= 1'b1;
                            ld_rd   <= ~rx_byte[7];
                            if (!rx_byte[7]) rd_addr <= rx_byte[2:0];
                        end else begin
                            out_sr <= 8'h00;
                            if (err_count != 4'hF) err_count <= err_count + 4'd1;
                        end
                    end else if (byte_done && state == DATA) begin
                        if (cmd_wr) begin
                            wr_pend  <= 1'b1;
                            wr_level <= rx_byte;
                        end
                        out_sr <= 8'h00;
                    end
                end else if (fall) begin
                    if (ld_pend) begin
                        out_sr  <= ld_rd ? rd_level : 8'h00;
                        ld_pend <= 1'b0;
                    end else begin
                        out_sr <= {out_sr[6:0], 1'b0};
                    end
                end
                if (cs_s) begin
                    bit_cnt <= '0;
                    ld_pend <= 1'b0;
                end
            end
        end
    end

    assign miso = out_sr[7];
    assign busy = (state != IDLE);

endmodule
